fetch_queue_nw: RTL and testbench
=================================

Name: fetch_queue_nw

Overview:
- Parametrised successor of the fetch-stage instruction buffer: a circular multi-port queue between multi-lane fetch and multi-lane decode.
- Enqueues up to FETCH_WIDTH entries per cycle and dequeues up to DECODE_WIDTH entries per cycle, both as in-order contiguous groups.
- New over the previous generation: parametric lane counts, opaque packed payload, optional partial-accept mode, almost-full threshold, per-entry parity with sticky fatal in secure mode.

Parameters:
- FETCH_WIDTH, 5: enqueue lanes.
- DECODE_WIDTH, 3: dequeue lanes.
- DEPTH, 16: entries; must be a power of 2, >= FETCH_WIDTH and >= DECODE_WIDTH.
- PAYLOAD_W, 140: bits per entry (instr, pc, imm, pred, pc_at_pred, ghist, ras_tos packed by the caller).
- PARTIAL_ACCEPT, 0: 1 = accept as many as fit; 0 = all-or-nothing.
- AFULL_THRESH, DEPTH-FETCH_WIDTH: almost_full_o asserts when occupancy >= this value.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all contents (eager mispredict flush).
- secure_mode  in  1  enables parity checking.
- fetch_valid_i  in  FETCH_WIDTH  lane-valid mask; contiguous prefix.
- fetch_payload_i  in  FETCH_WIDTH*PAYLOAD_W  lane i at [i*PAYLOAD_W +: PAYLOAD_W].
- fetch_ready_o  out  1  free >= FETCH_WIDTH.
- accept_cnt_o  out  $clog2(FETCH_WIDTH+1)  lanes written this cycle.
- decode_ready_i  in  DECODE_WIDTH  ready prefix mask.
- decode_valid_o  out  DECODE_WIDTH  thermometer mask, min(occupancy, DECODE_WIDTH) ones.
- decode_payload_o  out  DECODE_WIDTH*PAYLOAD_W  head-ordered entries.
- occupancy_o  out  $clog2(DEPTH)+1  stored count.
- empty_o / full_o / almost_full_o  out  1 each  status.
- fatal_o  out  1  sticky parity error.

Behaviour:
- Reset (async assert, sync release): head, tail and occupancy = 0; empty_o=1; full_o=0; almost_full_o=(AFULL_THRESH==0); fetch_ready_o=1; decode_valid_o=0; accept_cnt_o=0; fatal_o=0. Storage array is not reset; parity bits are reset to 0.
- in_cnt = number of leading ones in fetch_valid_i; bits after the first 0 are ignored.
- free = DEPTH - occupancy.
- Accept rule:
  - PARTIAL_ACCEPT=1: acc = min(in_cnt, free).
  - PARTIAL_ACCEPT=0: acc = (in_cnt <= free) ? in_cnt : 0.
- accept_cnt_o is combinational; fetch holds lanes >= acc for the next cycle.
- deq = min(leading ones of decode_ready_i, popcount(decode_valid_o)).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Lane i writes slot tail+i; decode lane j reads slot head+j.
- Next state: tail += acc; head += deq; occupancy += acc - deq. Simultaneous enqueue and dequeue are legal at full and at empty.
- Latency: an entry written in cycle N is first visible on decode_payload_o in cycle N+1. There is no bypass, so an empty queue shows decode_valid_o=0 even when fetch is valid.
- Decode outputs and status are combinational from registered state only (no input-to-output paths), except accept_cnt_o.
- flush_i has priority: head=tail=occupancy=0 next cycle; enqueue and dequeue that cycle are discarded; accept_cnt_o forced to 0. fatal_o is not cleared.
- Parity: even parity over the payload is stored per slot on write. When secure_mode=1, each valid decode lane is checked; a mismatch sets fatal_o on the next edge, held until reset.
- Reset asserted mid-operation: all state clears immediately; in-flight lanes are lost.
- Output bits of lanes with decode_valid_o=0 are don't-care.

Decomposition:
- Package fetch_queue_pkg holds: a function for leading-ones count and a function for thermometer generation, both width-parametric; the fq_status_t struct {empty, full, almost_full}; and the default payload layout typedef used by fetch_buffer integration.
- One sub-module, fq_prefix_count: leading-ones counter instantiated for both the fetch and decode masks.
- Storage, pointers and parity stay in the top module.

Test Plan:
- Reset then fetch_valid_i=5'b11111 for 3 cycles, decode_ready_i=0 → occupancy 5,10,15.
  - PARTIAL_ACCEPT=0: fourth group gets acc=0, fetch_ready_o=0 from occupancy 15.
  - PARTIAL_ACCEPT=1: fourth group gets acc=1, full_o=1.
- fetch_valid_i=5'b10111 on empty queue → acc=3; next cycle decode_valid_o=3'b111 with payloads of lanes 0,1,2 in order.
- Occupancy 16, decode_ready_i=3'b111 plus 5 valid fetch lanes, PARTIAL_ACCEPT=1 → acc=0, deq=3 → occupancy 13. Following cycle acc=3 → occupancy 16. Head wraps past slot 15 with correct ordering.
- decode_ready_i=3'b101 with 3 valid → deq=1 only; occupancy decreases by 1.
- flush_i with occupancy 9 and 5 fetch lanes valid → accept_cnt_o=0; next cycle occupancy 0, empty_o=1, decode_valid_o=0.
- secure_mode=1, force a bit flip in a stored slot → fatal_o=1 the cycle after that slot reaches a valid decode lane; stays 1 through flush; cleared only by reset.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue: lane-mask counting,
// thermometer masks, parity and the default packed payload layout.
package fetch_queue_pkg;

  localparam int unsigned MAX_LANES  = 32;
  localparam int unsigned LANE_CNT_W = 6;
  localparam int unsigned PAR_MAX_W  = 1024;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } fq_status_t;

  // Default entry layout used by the fetch_buffer integration (140 bits).
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic [31:0] pc_at_pred;
    logic [7:0]  ghist;
    logic [2:0]  ras_tos;
  } fq_payload_t;

  // Number of consecutive ones starting at bit 0; only the low 'width' bits count.
  function automatic logic [LANE_CNT_W-1:0] lead_ones(input logic [MAX_LANES-1:0] mask,
                                                       input int unsigned width);
    logic                  run;
    logic [LANE_CNT_W-1:0] cnt;
    run = 1'b1;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < width) begin
        run = run & mask[i];
      end else begin
        run = 1'b0;
      end
      cnt = cnt + LANE_CNT_W'(run);
    end
    return cnt;
  endfunction

  // Mask with the low n bits set.
  function automatic logic [MAX_LANES-1:0] thermo(input logic [LANE_CNT_W-1:0] n);
    logic [MAX_LANES-1:0] t;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      t[i] = (LANE_CNT_W'(i) < n);
    end
    return t;
  endfunction

  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fq_prefix_count.sv
// Leading-ones counter for a contiguous-prefix lane mask.
module fq_prefix_count
  import fetch_queue_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0]             mask,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(W + 1);

  // Count lanes up to the first cleared bit.
  always_comb begin
    count = CW'(lead_ones(MAX_LANES'(mask), W));
  end

endmodule

// File: rtl/fetch_queue_nw.sv
// Circular multi-port instruction queue between multi-lane fetch and decode.
// Enqueue/dequeue are in-order contiguous groups; decode sees entries one
// cycle after they are written (no bypass). Each slot carries an even parity
// bit that is checked on valid decode lanes in secure mode.
module fetch_queue_nw
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH    = 5,
  parameter int unsigned DECODE_WIDTH   = 3,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned PAYLOAD_W      = 140,
  parameter bit          PARTIAL_ACCEPT = 1'b0,
  parameter int unsigned AFULL_THRESH   = DEPTH - FETCH_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                secure_mode,
  input  logic [FETCH_WIDTH-1:0]              fetch_valid_i,
  input  logic [FETCH_WIDTH*PAYLOAD_W-1:0]    fetch_payload_i,
  output logic                                fetch_ready_o,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]    accept_cnt_o,
  input  logic [DECODE_WIDTH-1:0]             decode_ready_i,
  output logic [DECODE_WIDTH-1:0]             decode_valid_o,
  output logic [DECODE_WIDTH*PAYLOAD_W-1:0]   decode_payload_o,
  output logic [$clog2(DEPTH):0]              occupancy_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic                                almost_full_o,
  output logic                                fatal_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned ACC_W = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned DEQ_W = $clog2(DECODE_WIDTH + 1);

  logic [PAYLOAD_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]     par_r;
  logic [PTR_W-1:0]     head_r;
  logic [PTR_W-1:0]     tail_r;
  logic [OCC_W-1:0]     occ_r;
  logic                 fatal_r;

  logic [ACC_W-1:0]        in_cnt_s;
  logic [DEQ_W-1:0]        rdy_cnt_s;
  logic [OCC_W-1:0]        free_s;
  logic [OCC_W-1:0]        acc_s;
  logic [OCC_W-1:0]        vis_s;
  logic [OCC_W-1:0]        deq_s;
  logic [DECODE_WIDTH-1:0] dec_valid_s;
  logic                    par_err_s;
  fq_status_t              status_s;
  logic [PTR_W-1:0]        wr_slot_s [FETCH_WIDTH];
  logic [PTR_W-1:0]        rd_slot_s [DECODE_WIDTH];

  fq_prefix_count #(.W(FETCH_WIDTH)) u_fetch_cnt (
    .mask  (fetch_valid_i),
    .count (in_cnt_s)
  );

  fq_prefix_count #(.W(DECODE_WIDTH)) u_decode_cnt (
    .mask  (decode_ready_i),
    .count (rdy_cnt_s)
  );

  // Accepted lane count: flush wins, then all-or-nothing or partial fill.
  always_comb begin
    free_s = OCC_W'(DEPTH) - occ_r;
    acc_s  = '0;
    if (flush_i) begin
      acc_s = '0;
    end else if (OCC_W'(in_cnt_s) <= free_s) begin
      acc_s = OCC_W'(in_cnt_s);
    end else if (PARTIAL_ACCEPT) begin
      acc_s = free_s;
    end else begin
      acc_s = '0;
    end
  end

  // Visible entries and dequeue count (bounded by ready prefix and visibility).
  always_comb begin
    vis_s = (occ_r < OCC_W'(DECODE_WIDTH)) ? occ_r : OCC_W'(DECODE_WIDTH);
    deq_s = '0;
    if (flush_i) begin
      deq_s = '0;
    end else if (OCC_W'(rdy_cnt_s) < vis_s) begin
      deq_s = OCC_W'(rdy_cnt_s);
    end else begin
      deq_s = vis_s;
    end
    dec_valid_s = DECODE_WIDTH'(thermo(LANE_CNT_W'(vis_s)));
  end

  // Slot addresses for each write and read lane, wrapping modulo DEPTH.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_slot_s[i] = tail_r + PTR_W'(i);
    end
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      rd_slot_s[j] = head_r + PTR_W'(j);
    end
  end

  // Head-ordered decode payloads and parity check on valid lanes.
  always_comb begin
    decode_payload_o = '0;
    par_err_s        = 1'b0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      decode_payload_o[j*PAYLOAD_W +: PAYLOAD_W] = mem_r[rd_slot_s[j]];
      par_err_s = par_err_s | (secure_mode & dec_valid_s[j] &
                  (even_parity(PAR_MAX_W'(mem_r[rd_slot_s[j]])) ^ par_r[rd_slot_s[j]]));
    end
  end

  // Status flags derived from registered occupancy only.
  always_comb begin
    status_s.empty       = (occ_r == '0);
    status_s.full        = (occ_r == OCC_W'(DEPTH));
    status_s.almost_full = (occ_r >= OCC_W'(AFULL_THRESH));
  end

  assign fetch_ready_o  = (free_s >= OCC_W'(FETCH_WIDTH));
  assign accept_cnt_o   = ACC_W'(acc_s);
  assign decode_valid_o = dec_valid_s;
  assign occupancy_o    = occ_r;
  assign empty_o        = status_s.empty;
  assign full_o         = status_s.full;
  assign almost_full_o  = status_s.almost_full;
  assign fatal_o        = fatal_r;

  // Pointer and occupancy update; flush empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else if (flush_i) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else begin
      tail_r <= tail_r + PTR_W'(acc_s);
      head_r <= head_r + PTR_W'(deq_s);
      occ_r  <= occ_r + acc_s - deq_s;
    end
  end

  // Payload storage (no reset: contents are qualified by occupancy).
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (OCC_W'(i) < acc_s) begin
        mem_r[wr_slot_s[i]] <= fetch_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Per-slot parity captured alongside each accepted lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_r <= '0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (OCC_W'(i) < acc_s) begin
          par_r[wr_slot_s[i]] <= even_parity(PAR_MAX_W'(fetch_payload_i[i*PAYLOAD_W +: PAYLOAD_W]));
        end
      end
    end
  end

  // Sticky fatal flag: only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fatal_r <= 1'b0;
    end else if (par_err_s) begin
      fatal_r <= 1'b1;
    end else begin
      fatal_r <= fatal_r;
    end
  end

endmodule

// File: tb/tb_fetch_queue_nw.sv
// Directed bench for fetch_queue_nw: a partial-accept instance driven from a
// vector table with a tag-queue payload model, plus an all-or-nothing
// instance and hand sequences for fill, parity fatal and async reset.
module tb_fetch_queue_nw;

  localparam int FW  = 5;
  localparam int DW  = 3;
  localparam int DEP = 16;
  localparam int PW  = 140;
  localparam int NV  = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           flush_i;
  logic           secure_mode;
  logic [FW-1:0]  fetch_valid_i;
  logic [FW*PW-1:0] fetch_payload_i;
  logic [DW-1:0]  decode_ready_i;

  logic           fready_a, fready_b;
  logic [2:0]     acc_a, acc_b;
  logic [DW-1:0]  dv_a, dv_b;
  logic [DW*PW-1:0] dp_a, dp_b;
  logic [4:0]     occ_a, occ_b;
  logic           empty_a, empty_b, full_a, full_b, afull_a, afull_b, fatal_a, fatal_b;

  fetch_queue_nw #(.PARTIAL_ACCEPT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush_i(flush_i), .secure_mode(secure_mode),
    .fetch_valid_i(fetch_valid_i), .fetch_payload_i(fetch_payload_i),
    .fetch_ready_o(fready_a), .accept_cnt_o(acc_a), .decode_ready_i(decode_ready_i),
    .decode_valid_o(dv_a), .decode_payload_o(dp_a), .occupancy_o(occ_a),
    .empty_o(empty_a), .full_o(full_a), .almost_full_o(afull_a), .fatal_o(fatal_a)
  );

  fetch_queue_nw #(.PARTIAL_ACCEPT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush_i(flush_i), .secure_mode(secure_mode),
    .fetch_valid_i(fetch_valid_i), .fetch_payload_i(fetch_payload_i),
    .fetch_ready_o(fready_b), .accept_cnt_o(acc_b), .decode_ready_i(decode_ready_i),
    .decode_valid_o(dv_b), .decode_payload_o(dp_b), .occupancy_o(occ_b),
    .empty_o(empty_b), .full_o(full_b), .almost_full_o(afull_b), .fatal_o(fatal_b)
  );

  typedef struct {
    logic          flush;
    logic [FW-1:0] fv;
    logic [DW-1:0] dr;
    int            e_acc;
    int            e_deq;
    int            e_occ;
    logic [DW-1:0] e_dv;
  } vec_t;

  vec_t       tbl [NV];
  logic [7:0] q [$];
  logic [DEP-1:0] forced_par;
  int checks = 0;
  int errors = 0;

  function automatic logic [PW-1:0] mk(input logic [7:0] t);
    return {{17{t}}, t[3:0]};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_tags(input int base);
    for (int i = 0; i < FW; i++) fetch_payload_i[i*PW +: PW] = mk(8'(base + i));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush_i = 1'b0; secure_mode = 1'b0;
    fetch_valid_i = '0; decode_ready_i = '0; fetch_payload_i = '0;

    tbl[0]  = '{1'b0, 5'b11111, 3'b000, 5, 0, 0,  3'b000};
    tbl[1]  = '{1'b0, 5'b11111, 3'b000, 5, 0, 5,  3'b111};
    tbl[2]  = '{1'b0, 5'b11111, 3'b000, 5, 0, 10, 3'b111};
    tbl[3]  = '{1'b0, 5'b11111, 3'b000, 1, 0, 15, 3'b111};
    tbl[4]  = '{1'b0, 5'b11111, 3'b111, 0, 3, 16, 3'b111};
    tbl[5]  = '{1'b0, 5'b11111, 3'b000, 3, 0, 13, 3'b111};
    tbl[6]  = '{1'b0, 5'b00000, 3'b111, 0, 3, 16, 3'b111};
    tbl[7]  = '{1'b0, 5'b00000, 3'b111, 0, 3, 13, 3'b111};
    tbl[8]  = '{1'b0, 5'b00000, 3'b111, 0, 3, 10, 3'b111};
    tbl[9]  = '{1'b0, 5'b00000, 3'b101, 0, 1, 7,  3'b111};
    tbl[10] = '{1'b0, 5'b00000, 3'b111, 0, 3, 6,  3'b111};
    tbl[11] = '{1'b0, 5'b10111, 3'b011, 3, 2, 3,  3'b111};
    tbl[12] = '{1'b0, 5'b00000, 3'b111, 0, 3, 4,  3'b111};
    tbl[13] = '{1'b0, 5'b00001, 3'b111, 1, 1, 1,  3'b001};
    tbl[14] = '{1'b0, 5'b00000, 3'b111, 0, 1, 1,  3'b001};
    tbl[15] = '{1'b0, 5'b11111, 3'b111, 5, 0, 0,  3'b000};
    tbl[16] = '{1'b0, 5'b01111, 3'b000, 4, 0, 5,  3'b111};
    tbl[17] = '{1'b1, 5'b11111, 3'b111, 0, 0, 9,  3'b111};
    tbl[18] = '{1'b0, 5'b00000, 3'b000, 0, 0, 0,  3'b000};
    tbl[19] = '{1'b0, 5'b10111, 3'b000, 3, 0, 0,  3'b000};
    tbl[20] = '{1'b0, 5'b00000, 3'b111, 0, 3, 3,  3'b111};
    tbl[21] = '{1'b0, 5'b00000, 3'b000, 0, 0, 0,  3'b000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst occ", PW'(occ_a), PW'(0));
    chk("rst empty", PW'(empty_a), PW'(1));
    chk("rst full", PW'(full_a), PW'(0));
    chk("rst afull", PW'(afull_a), PW'(0));
    chk("rst fready", PW'(fready_a), PW'(1));
    chk("rst dvalid", PW'(dv_a), PW'(0));
    chk("rst acc", PW'(acc_a), PW'(0));
    chk("rst fatal", PW'(fatal_a), PW'(0));
    chk("rst occ b", PW'(occ_b), PW'(0));
    next_cycle();
    reset = 1'b1;

    // Fill both instances with full groups; they differ on the fourth group.
    fetch_valid_i = 5'b11111;
    drive_tags(8'hA0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("fill%0d occ b", c), PW'(occ_b), PW'(c * 5));
      if (c < 3) begin
        chk($sformatf("fill%0d acc b", c), PW'(acc_b), PW'(5));
        chk($sformatf("fill%0d fready b", c), PW'(fready_b), PW'(1));
      end else begin
        chk("fill3 acc b", PW'(acc_b), PW'(0));
        chk("fill3 fready b", PW'(fready_b), PW'(0));
        chk("fill3 acc a", PW'(acc_a), PW'(1));
      end
      next_cycle();
    end
    @(negedge clk);
    chk("fill occ b hold", PW'(occ_b), PW'(15));
    chk("fill occ a", PW'(occ_a), PW'(16));
    chk("fill full a", PW'(full_a), PW'(1));
    chk("fill full b", PW'(full_b), PW'(0));
    next_cycle();
    fetch_valid_i = '0;
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    secure_mode = 1'b1;

    // Table-driven run on the partial-accept instance
    for (int k = 0; k < NV; k++) begin
      flush_i        = tbl[k].flush;
      fetch_valid_i  = tbl[k].fv;
      decode_ready_i = tbl[k].dr;
      drive_tags(k * 5 + 1);
      @(negedge clk);
      chk($sformatf("r%0d acc", k), PW'(acc_a), PW'(tbl[k].e_acc));
      chk($sformatf("r%0d occ", k), PW'(occ_a), PW'(tbl[k].e_occ));
      chk($sformatf("r%0d dvalid", k), PW'(dv_a), PW'(tbl[k].e_dv));
      chk($sformatf("r%0d empty", k), PW'(empty_a), PW'(tbl[k].e_occ == 0));
      chk($sformatf("r%0d full", k), PW'(full_a), PW'(tbl[k].e_occ == DEP));
      chk($sformatf("r%0d afull", k), PW'(afull_a), PW'(tbl[k].e_occ >= DEP - FW));
      chk($sformatf("r%0d fready", k), PW'(fready_a), PW'(DEP - tbl[k].e_occ >= FW));
      chk($sformatf("r%0d fatal", k), PW'(fatal_a), PW'(0));
      for (int j = 0; j < DW; j++) begin
        if (tbl[k].e_dv[j]) begin
          if (j < q.size()) begin
            chk($sformatf("r%0d lane%0d payload", k, j), dp_a[j*PW +: PW], mk(q[j]));
          end else begin
            checks++;
            errors++;
            $display("FAIL r%0d lane%0d payload: model holds %0d entries", k, j, q.size());
          end
        end
      end
      for (int d = 0; d < tbl[k].e_deq; d++) void'(q.pop_front());
      for (int i = 0; i < tbl[k].e_acc; i++) q.push_back(8'(k * 5 + 1 + i));
      if (tbl[k].flush) q.delete();
      next_cycle();
    end

    // Parity fault: corrupt slot 4's stored parity, then move it into the decode window.
    flush_i = 1'b1; fetch_valid_i = '0; decode_ready_i = '0;
    next_cycle();
    flush_i = 1'b0;
    fetch_valid_i = 5'b11111;
    drive_tags(8'hC0);
    next_cycle();
    fetch_valid_i = '0;
    @(negedge clk);
    chk("par occ", PW'(occ_a), PW'(5));
    chk("par fatal clean", PW'(fatal_a), PW'(0));
    forced_par = dut_a.par_r ^ 16'h0010;
    force dut_a.par_r = forced_par;
    next_cycle();
    @(negedge clk);
    chk("par fatal outside window", PW'(fatal_a), PW'(0));
    decode_ready_i = 3'b111;
    next_cycle();
    decode_ready_i = '0;
    @(negedge clk);
    chk("par dvalid", PW'(dv_a), PW'(3'b011));
    chk("par fatal before edge", PW'(fatal_a), PW'(0));
    next_cycle();
    @(negedge clk);
    chk("par fatal set", PW'(fatal_a), PW'(1));
    chk("par fatal b clean", PW'(fatal_b), PW'(0));
    release dut_a.par_r;
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    chk("par fatal after flush", PW'(fatal_a), PW'(1));
    chk("par occ after flush", PW'(occ_a), PW'(0));
    next_cycle();

    // Asynchronous reset mid-operation
    fetch_valid_i = 5'b11111;
    next_cycle();
    fetch_valid_i = '0;
    #2;
    chk("pre areset occ", PW'(occ_a), PW'(5));
    reset = 1'b0;
    #1;
    chk("areset occ", PW'(occ_a), PW'(0));
    chk("areset fatal", PW'(fatal_a), PW'(0));
    chk("areset empty", PW'(empty_a), PW'(1));
    chk("areset dvalid", PW'(dv_a), PW'(0));
    next_cycle();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
